// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// flush-depth limits and the flush down-counter load helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } haz_state_e;

  localparam int FLUSH_DEPTH_MIN = 1;
  localparam int FLUSH_DEPTH_MAX = 4;
  localparam int FLUSH_CNT_W     = 2;

  // The down-counter starts at depth-1 so it reaches zero on the last flush cycle.
  function automatic logic [FLUSH_CNT_W-1:0] flush_load_val(input int depth);
    int d;
    d = depth;
    if (d < FLUSH_DEPTH_MIN) d = FLUSH_DEPTH_MIN;
    if (d > FLUSH_DEPTH_MAX) d = FLUSH_DEPTH_MAX;
    return FLUSH_CNT_W'(d - 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_pick.sv
// fwd_pick: priority match of one ID source register against all downstream
// destinations; the youngest (lowest-index) writing stage wins, x0 never matches.
module fwd_pick #(
  parameter  int RA_W  = 5,
  parameter  int NSTG  = 3,
  localparam int SEL_W = $clog2(NSTG + 1)
) (
  input  logic [RA_W-1:0]      rs_addr,
  input  logic                 rs_used,
  input  logic [NSTG*RA_W-1:0] rd_addr,
  input  logic [NSTG-1:0]      wb_en,
  output logic [SEL_W-1:0]     sel
);

  logic [NSTG-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NSTG; k++) begin
      hit[k] = rs_used & wb_en[k]
             & (rd_addr[k*RA_W +: RA_W] != '0)
             & (rd_addr[k*RA_W +: RA_W] == rs_addr);
    end
    // Scan oldest to youngest so the youngest hit overwrites the older ones.
    sel = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: registered operand forwarding, load-use and
// memory-wait stalls, redirect flush FSM. Optional perf counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int RA_W        = 5,
  parameter  int NSTG        = 3,
  parameter  int FLUSH_DEPTH = 2,
  localparam int SEL_W       = $clog2(NSTG + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RA_W-1:0]      rs1_addr,
  input  logic [RA_W-1:0]      rs2_addr,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [NSTG*RA_W-1:0] rd_addr,
  input  logic [NSTG-1:0]      wb_en,
  input  logic                 ex_is_load,
  input  logic                 redirect,
  input  logic                 dm_ready,
  input  logic                 mem_access,
  output logic [SEL_W-1:0]     fwd_sel1,
  output logic [SEL_W-1:0]     fwd_sel2,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic [1:0]           state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]      stall_cnt,
  output logic [XLEN-1:0]      flush_cnt
`endif
);

  if (FLUSH_DEPTH < FLUSH_DEPTH_MIN || FLUSH_DEPTH > FLUSH_DEPTH_MAX || XLEN < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: FLUSH_DEPTH must be 1..4 and XLEN positive");
  end

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = flush_load_val(FLUSH_DEPTH);

  haz_state_e             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   flush_q, flush_d;
  logic [SEL_W-1:0]       fwd_sel1_q, fwd_sel1_d;
  logic [SEL_W-1:0]       fwd_sel2_q, fwd_sel2_d;
  logic [SEL_W-1:0]       pick1, pick2;
  logic [RA_W-1:0]        rd_ex;
  logic                   mem_stall, ex_hit, load_use, flush_entry;

  fwd_pick #(.RA_W(RA_W), .NSTG(NSTG)) u_pick1 (
    .rs_addr (rs1_addr),
    .rs_used (rs1_used),
    .rd_addr (rd_addr),
    .wb_en   (wb_en),
    .sel     (pick1)
  );

  fwd_pick #(.RA_W(RA_W), .NSTG(NSTG)) u_pick2 (
    .rs_addr (rs2_addr),
    .rs_used (rs2_used),
    .rd_addr (rd_addr),
    .wb_en   (wb_en),
    .sel     (pick2)
  );

  // Stall decode is gated by rst so the pipeline sees no stall while in reset.
  always_comb begin
    rd_ex     = rd_addr[RA_W-1:0];
    mem_stall = ~rst & mem_access & ~dm_ready;
    ex_hit    = wb_en[0] & (rd_ex != '0)
              & ((rs1_used & (rs1_addr == rd_ex)) | (rs2_used & (rs2_addr == rd_ex)));
    load_use  = ~rst & (state_q == RUN) & ~mem_stall & ~redirect & ex_is_load & ex_hit;
    stall_if  = mem_stall | load_use;
    stall_id  = mem_stall | load_use;
    stall_ex  = mem_stall;
    stall_mem = mem_stall;
    bubble_ex = load_use;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (mem_stall) begin
      state_d = MEMWAIT;
      cnt_d   = '0;
      // A redirect during FLUSH belongs to a wrong-path instruction.
      if (redirect && state_q != FLUSH) pend_d = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (redirect) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        MEMWAIT: begin
          if (pend_q || redirect) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
    flush_d     = (state_d == FLUSH);
    flush_entry = (state_d == FLUSH) && (state_q != FLUSH);
    fwd_sel1_d  = stall_id ? fwd_sel1_q : pick1;
    fwd_sel2_d  = stall_id ? fwd_sel2_q : pick2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      flush_q    <= 1'b0;
      fwd_sel1_q <= '0;
      fwd_sel2_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      fwd_sel1_q <= fwd_sel1_d;
      fwd_sel2_q <= fwd_sel2_d;
    end
  end

  assign fwd_sel1 = fwd_sel1_q;
  assign fwd_sel2 = fwd_sel2_q;
  assign flush_id = flush_q;
  assign flush_ex = flush_q;
  assign state    = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + XLEN'(stall_if);
    flush_cnt_d = flush_cnt_q + XLEN'(flush_entry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_flush_entry;
  assign unused_flush_entry = flush_entry;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// scored against a cycle-level reference model through an expectation queue.
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int NSTG  = 3;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RA_W-1:0]      rs1_addr, rs2_addr;
  logic                 rs1_used, rs2_used;
  logic [NSTG*RA_W-1:0] rd_addr;
  logic [NSTG-1:0]      wb_en;
  logic                 ex_is_load, redirect, dm_ready, mem_access;
  logic [1:0]           fwd_sel1, fwd_sel2;
  logic                 stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
  logic                 flush_id, flush_ex;
  logic [1:0]           state;
`ifdef HAZ_PERF_CNT_EN
  logic [XLEN-1:0]      stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .FLUSH_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rd_addr    (rd_addr),
    .wb_en      (wb_en),
    .ex_is_load (ex_is_load),
    .redirect   (redirect),
    .dm_ready   (dm_ready),
    .mem_access (mem_access),
    .fwd_sel1   (fwd_sel1),
    .fwd_sel2   (fwd_sel2),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .stall_ex   (stall_ex),
    .stall_mem  (stall_mem),
    .bubble_ex  (bubble_ex),
    .flush_id   (flush_id),
    .flush_ex   (flush_ex),
    .state      (state)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  typedef struct {
    bit         rst;
    logic [4:0] rs1, rs2;
    bit         u1, u2;
    logic [4:0] rd1, rd2, rd3;
    logic [2:0] wb;
    bit         ld, redir, dmr, macc;
  } stim_t;

  typedef struct {
    logic [1:0]  sel1, sel2, st;
    logic        s_if, s_id, s_ex, s_mem, bub, f_id, f_ex;
    logic [31:0] scnt, fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: remaining flush cycles, memory-wait flag, pending redirect.
  int          m_flush_left;
  bit          m_memwait, m_pend;
  int          m_sel1, m_sel2;
  logic [31:0] m_scnt, m_fcnt;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.u1 = 0; s.u2 = 0;
    s.rd1 = 0; s.rd2 = 0; s.rd3 = 0; s.wb = 3'b000;
    s.ld = 0; s.redir = 0; s.dmr = 1; s.macc = 0;
    return s;
  endfunction

  function automatic int ref_pick(logic [4:0] rs, bit used, logic [4:0] rd1,
                                  logic [4:0] rd2, logic [4:0] rd3, logic [2:0] wb);
    logic [4:0] rd [3];
    rd[0] = rd1; rd[1] = rd2; rd[2] = rd3;
    if (!used || rs == 5'd0) return 0;
    for (int k = 1; k <= 3; k++) begin
      if (wb[k-1] && rd[k-1] == rs) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_memwait = 0; m_pend = 0;
    m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    int   st;
    bit   ms, ex_hit, lu, entered;
    rst        = s.rst;
    rs1_addr   = s.rs1;  rs2_addr = s.rs2;
    rs1_used   = s.u1;   rs2_used = s.u2;
    rd_addr    = {s.rd3, s.rd2, s.rd1};
    wb_en      = s.wb;
    ex_is_load = s.ld;   redirect = s.redir;
    dm_ready   = s.dmr;  mem_access = s.macc;
    if (s.rst) begin
      model_reset();
      e.sel1 = 0; e.sel2 = 0; e.st = 0;
      e.s_if = 0; e.s_id = 0; e.s_ex = 0; e.s_mem = 0; e.bub = 0;
      e.f_id = 0; e.f_ex = 0; e.scnt = 0; e.fcnt = 0;
      exp_q.push_back(e);
    end else begin
      st     = m_memwait ? 2 : (m_flush_left > 0 ? 1 : 0);
      ms     = s.macc && !s.dmr;
      ex_hit = s.wb[0] && s.rd1 != 0 &&
               ((s.u1 && s.rs1 == s.rd1) || (s.u2 && s.rs2 == s.rd1));
      lu     = (st == 0) && !ms && !s.redir && s.ld && ex_hit;
      e.sel1 = 2'(m_sel1); e.sel2 = 2'(m_sel2); e.st = 2'(st);
      e.s_if = ms || lu; e.s_id = ms || lu; e.s_ex = ms; e.s_mem = ms;
      e.bub  = lu; e.f_id = (st == 1); e.f_ex = (st == 1);
      e.scnt = m_scnt; e.fcnt = m_fcnt;
      exp_q.push_back(e);
      if (!e.s_id) begin
        m_sel1 = ref_pick(s.rs1, s.u1, s.rd1, s.rd2, s.rd3, s.wb);
        m_sel2 = ref_pick(s.rs2, s.u2, s.rd1, s.rd2, s.rd3, s.wb);
      end
      if (e.s_if) m_scnt = m_scnt + 1;
      entered = 0;
      if (ms) begin
        if (s.redir && st != 1) m_pend = 1;
        m_memwait = 1;
        m_flush_left = 0;
      end else if (st == 0) begin
        if (s.redir) begin m_flush_left = DEPTH; entered = 1; end
      end else if (st == 1) begin
        m_flush_left = m_flush_left - 1;
      end else begin
        m_memwait = 0;
        if (m_pend || s.redir) begin m_flush_left = DEPTH; m_pend = 0; entered = 1; end
      end
      if (entered) m_fcnt = m_fcnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("fwd_sel1",  32'(fwd_sel1),  32'(e.sel1));
    check_field("fwd_sel2",  32'(fwd_sel2),  32'(e.sel2));
    check_field("state",     32'(state),     32'(e.st));
    check_field("stall_if",  32'(stall_if),  32'(e.s_if));
    check_field("stall_id",  32'(stall_id),  32'(e.s_id));
    check_field("stall_ex",  32'(stall_ex),  32'(e.s_ex));
    check_field("stall_mem", 32'(stall_mem), 32'(e.s_mem));
    check_field("bubble_ex", 32'(bubble_ex), 32'(e.bub));
    check_field("flush_id",  32'(flush_id),  32'(e.f_id));
    check_field("flush_ex",  32'(flush_ex),  32'(e.f_ex));
`ifdef HAZ_PERF_CNT_EN
    check_field("stall_cnt", stall_cnt, e.scnt);
    check_field("flush_cnt", flush_cnt, e.fcnt);
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    stim_t s;
    rst = 1'b1;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    rd_addr = 0; wb_en = 0; ex_is_load = 0; redirect = 0; dm_ready = 1; mem_access = 0;
    model_reset();
    @(posedge clk);
    #1;
    s = idle(); s.rst = 1;
    repeat (2) apply_stimulus(s);
    apply_stimulus(idle());

    $display("[TB] EX forwarding priority");
    s = idle(); s.rd1 = 5; s.wb = 3'b111; s.rs1 = 5; s.u1 = 1;
    apply_stimulus(s);
    s.rd2 = 5;
    apply_stimulus(s);
    apply_stimulus(idle());

    $display("[TB] load-use stall");
    s = idle(); s.ld = 1; s.rd1 = 7; s.wb = 3'b111; s.rs2 = 7; s.u2 = 1;
    apply_stimulus(s);
    s.ld = 0; s.rd1 = 0; s.rd2 = 7;
    apply_stimulus(s);
    apply_stimulus(s);
    apply_stimulus(idle());

    $display("[TB] redirect flush with wrong-path load-use");
    apply_stimulus(idle());
    s = idle(); s.redir = 1;
    apply_stimulus(s);
    s = idle(); s.ld = 1; s.rd1 = 7; s.wb = 3'b111; s.rs2 = 7; s.u2 = 1;
    apply_stimulus(s);
    repeat (3) apply_stimulus(idle());

    $display("[TB] memory wait with coincident redirect");
    s = idle(); s.macc = 1; s.dmr = 0; s.redir = 1;
    apply_stimulus(s);
    s.redir = 0;
    repeat (2) apply_stimulus(s);
    repeat (5) apply_stimulus(idle());

    $display("[TB] x0 never forwards or hazards");
    s = idle(); s.ld = 1; s.rd1 = 0; s.wb = 3'b111; s.rs1 = 0; s.u1 = 1;
    repeat (2) apply_stimulus(s);

    $display("[TB] reset in the middle of a flush");
    s = idle(); s.redir = 1;
    apply_stimulus(s);
    apply_stimulus(idle());
    s = idle(); s.rst = 1; s.macc = 1; s.dmr = 0; s.ld = 1; s.rd1 = 3; s.wb = 3'b111;
    s.rs1 = 3; s.u1 = 1;
    repeat (2) apply_stimulus(s);
    repeat (3) apply_stimulus(idle());

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      s.rst   = ($urandom_range(0, 199) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = $urandom_range(0, 1) == 1;
      s.u2    = $urandom_range(0, 1) == 1;
      s.rd1   = 5'($urandom_range(0, 3));
      s.rd2   = 5'($urandom_range(0, 3));
      s.rd3   = 5'($urandom_range(0, 3));
      s.wb    = 3'($urandom_range(0, 7));
      s.ld    = $urandom_range(0, 1) == 1;
      s.redir = $urandom_range(0, 7) == 0;
      s.macc  = $urandom_range(0, 2) == 0;
      s.dmr   = $urandom_range(0, 1) == 1;
      apply_stimulus(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; drives only the perf-counter width.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have parameter NSTG, default 3, forwarding source count (1=EX, 2=MEM, 3=WB; lower index is younger).
REQ-004 SHALL have parameter FLUSH_DEPTH, default 2, range 1..4, flush cycles after a redirect.
REQ-005 SHALL use ports, in order: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have rs1_addr/rs2_addr in RA_W each: ID source registers; rs1_used/rs2_used in 1 each: ID instruction reads the source.
REQ-007 SHALL have rd_addr in NSTG*RA_W (packed, stage k at slice k-1) and wb_en in NSTG: downstream destinations and write enables.
REQ-008 SHALL have ex_is_load in 1 (EX holds a load); redirect in 1 (EX resolved taken branch/jump); dm_ready in 1 (data memory accepts/completes the MEM access); mem_access in 1 (MEM holds load/store).
REQ-009 SHALL have outputs fwd_sel1/fwd_sel2 out $clog2(NSTG+1): registered operand source, 0 = register file.
REQ-010 SHALL have outputs stall_if, stall_id, stall_ex, stall_mem, bubble_ex (1 each, combinational) and flush_id, flush_ex (1 each, registered).
REQ-011 SHALL have output state out 2: current FSM state, for debug.

Function
REQ-012 SHALL implement FSM states RUN=0, FLUSH=1, MEMWAIT=2.
REQ-013 SHALL raise mem_stall = mem_access & ~dm_ready in any state.
REQ-014 SHALL, while mem_stall is high, hold all four stall_* outputs high, keep bubble_ex low, and hold the FSM in MEMWAIT.
REQ-015 SHALL leave MEMWAIT in the first cycle after dm_ready rises: to FLUSH if a redirect is pending, else to RUN.
REQ-016 SHALL, in RUN with mem_stall low and redirect high in cycle N, enter FLUSH and drive flush_id=flush_ex=1 in cycles N+1..N+FLUSH_DEPTH, counted by a down-counter.
REQ-017 SHALL return to RUN after the last flush cycle.
REQ-018 SHALL ignore redirect and load-use in FLUSH, since those are wrong-path instructions.
REQ-019 SHALL latch redirect as pending when it coincides with mem_stall, clear it on FLUSH entry, and ignore a second redirect while one is pending.
REQ-020 SHALL detect load-use, only in RUN with mem_stall low: ex_is_load & wb_en[0] & rd_addr[EX]!=0 & ((rs1_used & rs1_addr==rd_addr[EX]) | (rs2_used & rs2_addr==rd_addr[EX])).
REQ-021 SHALL, on load-use, assert stall_if, stall_id and bubble_ex for that cycle only, with stall_ex and stall_mem low.
REQ-022 SHALL give redirect priority over load-use in the same cycle, with no stall.
REQ-023 SHALL, each cycle stall_id is low, register fwd_selX = the smallest k with wb_en[k-1] & rd_addr[k]!=0 & rd_addr[k]==rsX_addr & rsX_used, else 0.
REQ-024 SHALL hold fwd_selX while stall_id is high.
REQ-025 SHALL register fwd_selX with all NSTG comparisons done in parallel and no combinational path from inputs to fwd_selX.
REQ-026 SHALL treat register address 0 as never forwarded and never hazarding.

Reset
REQ-027 SHALL, on rst, immediately set state=RUN, fwd_sel1=fwd_sel2=0, flush_id=flush_ex=0, flush counter 0, pending redirect 0, and perf counters 0.
REQ-028 SHALL, during reset, drive combinational stall_* and bubble_ex low whatever the inputs.
REQ-029 SHALL, when rst asserts mid-FLUSH or mid-MEMWAIT, abandon the operation with no residual flush after release.

Configuration
REQ-030 SHALL, with macro HAZ_PERF_CNT_EN defined, add outputs stall_cnt and flush_cnt, each XLEN wide, wrapping modulo 2^XLEN.
REQ-031 SHALL increment stall_cnt each cycle stall_if is high and flush_cnt once per FLUSH entry.
REQ-032 SHALL, without HAZ_PERF_CNT_EN, omit those ports and counters, leaving all other behaviour identical.

Structure
REQ-033 SHALL place the FSM state enum and FLUSH_DEPTH range limits in shared package hazard_pkg.
REQ-034 SHALL use one sub-module, fwd_pick, instantiated twice: priority match producing one fwd_sel.

Verification
REQ-035 SHALL cover EX-forward: rd_addr[EX]=5, wb_en=3'b111, rs1=5 used -> fwd_sel1=1 next cycle; with rd_addr[MEM]=5 too -> still 1.
REQ-036 SHALL cover load-use: ex_is_load=1, rd_addr[EX]=7, rs2=7 used -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; next cycle fwd_sel2=2.
REQ-037 SHALL cover redirect: pulse in cycle 10, FLUSH_DEPTH=2 -> flush_id=flush_ex=1 in cycles 11-12, state back to RUN in cycle 13; load-use in cycle 11 gives no stall.
REQ-038 SHALL cover memwait plus redirect: dm_ready=0 with mem_access=1 for 3 cycles, redirect in the first -> all stall_*=1 for 3 cycles, then flush for FLUSH_DEPTH cycles.
REQ-039 SHALL cover x0 and reset: rd_addr[EX]=0 with rs1=0 -> fwd_sel1=0, no stall; rst mid-FLUSH -> after release flush_*=0 and state=RUN.
REQ-040 SHALL cover the perf counters with HAZ_PERF_CNT_EN: after the two scenarios above, stall_cnt=4 and flush_cnt=2.
